// File: rtl/lz_search_window.sv
// rtl/lz_search_window.sv - LZ77 sliding search window with a registered nearest-match probe.
module lz_search_window #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 7,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    flush,
  input  logic                    probe_valid,
  input  logic [DATA_W-1:0]       probe_data,
  output logic [DEPTH*DATA_W-1:0] window_out,
  output logic [DEPTH-1:0]        valid_mask,
  output logic [CNT_W-1:0]        fill_count,
  output logic                    full,
  output logic                    match_valid,
  output logic                    match_hit,
  output logic [CNT_W-1:0]        match_offset,
  output logic [DEPTH-1:0]        match_mask
);

  logic [DATA_W-1:0] entry [DEPTH];
  logic              push;
  logic [DEPTH-1:0]  cmp;
  logic [CNT_W-1:0]  cmp_off;

  assign in_ready = ~flush;
  assign push     = in_valid & ~flush;
  assign full     = (fill_count == CNT_W'(DEPTH));

  for (genvar g = 0; g < DEPTH; g++) begin : g_win
    assign window_out[g*DATA_W +: DATA_W] = entry[g];
  end

  // Compare against the registered window so the probe never sees a same-cycle push or flush.
  always_comb begin
    cmp     = '0;
    cmp_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmp[i] = (entry[i] == probe_data) & valid_mask[i];
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cmp[i]) cmp_off = CNT_W'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      valid_mask   <= '0;
      fill_count   <= '0;
      match_valid  <= 1'b0;
      match_hit    <= 1'b0;
      match_offset <= '0;
      match_mask   <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
        valid_mask <= '0;
        fill_count <= '0;
      end else if (push) begin
        entry[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) entry[i] <= entry[i-1];
        valid_mask <= {valid_mask[DEPTH-2:0], 1'b1};
        if (fill_count != CNT_W'(DEPTH)) fill_count <= fill_count + CNT_W'(1);
      end
      match_valid <= probe_valid;
      if (probe_valid) begin
        match_mask   <= cmp;
        match_hit    <= |cmp;
        match_offset <= cmp_off;
      end
    end
  end

endmodule

// File: tb/tb_lz_search_window.sv
// tb/tb_lz_search_window.sv - directed and random checks of lz_search_window against a queue model.
module tb_lz_search_window;

  localparam int DS = 7,  WS = 8,  CS = $clog2(DS + 1);
  localparam int DL = 32, WL = 16, CL = $clog2(DL + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, flush, probe_valid;
  logic [WS-1:0] in_data_s, probe_s;
  logic [WL-1:0] in_data_l, probe_l;

  logic            rdy_s, full_s, mv_s, hit_s;
  logic [DS*WS-1:0] win_s;
  logic [DS-1:0]   vm_s, mm_s;
  logic [CS-1:0]   fc_s, off_s;

  logic            rdy_l, full_l, mv_l, hit_l;
  logic [DL*WL-1:0] win_l;
  logic [DL-1:0]   vm_l, mm_l;
  logic [CL-1:0]   fc_l, off_l;

  lz_search_window #(.DATA_W(WS), .DEPTH(DS)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data_s),
    .flush(flush), .probe_valid(probe_valid), .probe_data(probe_s),
    .window_out(win_s), .valid_mask(vm_s), .fill_count(fc_s), .full(full_s),
    .match_valid(mv_s), .match_hit(hit_s), .match_offset(off_s), .match_mask(mm_s));

  lz_search_window #(.DATA_W(WL), .DEPTH(DL)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data_l),
    .flush(flush), .probe_valid(probe_valid), .probe_data(probe_l),
    .window_out(win_l), .valid_mask(vm_l), .fill_count(fc_l), .full(full_l),
    .match_valid(mv_l), .match_hit(hit_l), .match_offset(off_l), .match_mask(mm_l));

  int vectors = 0;
  int miscompares = 0;

  // Reference state: newest literal at index 0, plus the held probe result.
  int q_s[$];
  int q_l[$];
  bit          e_mv;
  logic [31:0] e_mm_s, e_mm_l;
  int          e_off_s, e_off_l;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] win_of(input int q[$], input int w);
    logic [511:0] r = '0;
    for (int i = 0; i < q.size(); i++) r |= (512'(q[i]) << (i * w));
    return r;
  endfunction

  function automatic logic [31:0] ones(input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic probe_model(input int q[$], input int p, output logic [31:0] m, output int off);
    m = '0;
    off = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] == p) begin
        m[i] = 1'b1;
        if (off == 0) off = i + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("win_s", 512'(win_s), win_of(q_s, WS));
    chk("mask_s", 512'(vm_s), 512'(ones(q_s.size())));
    chk("fill_s", 512'(fc_s), 512'(q_s.size()));
    chk("full_s", 512'(full_s), 512'(q_s.size() == DS));
    chk("mvalid_s", 512'(mv_s), 512'(e_mv));
    chk("hit_s", 512'(hit_s), 512'(e_off_s != 0));
    chk("off_s", 512'(off_s), 512'(e_off_s));
    chk("mmask_s", 512'(mm_s), 512'(e_mm_s[DS-1:0]));
    chk("win_l", 512'(win_l), win_of(q_l, WL));
    chk("mask_l", 512'(vm_l), 512'(ones(q_l.size())));
    chk("fill_l", 512'(fc_l), 512'(q_l.size()));
    chk("full_l", 512'(full_l), 512'(q_l.size() == DL));
    chk("mvalid_l", 512'(mv_l), 512'(e_mv));
    chk("hit_l", 512'(hit_l), 512'(e_off_l != 0));
    chk("off_l", 512'(off_l), 512'(e_off_l));
    chk("mmask_l", 512'(mm_l), 512'(e_mm_l));
  endtask

  task automatic step(input bit iv, input logic [15:0] d, input bit fl, input bit pv, input logic [15:0] pd);
    @(negedge clk);
    in_valid = iv; flush = fl; probe_valid = pv;
    in_data_l = d; in_data_s = d[7:0];
    probe_l = pd; probe_s = pd[7:0];
    #1;
    chk("in_ready_s", 512'(rdy_s), 512'(!fl));
    chk("in_ready_l", 512'(rdy_l), 512'(!fl));
    @(posedge clk);
    if (!rst) begin
      q_s.delete(); q_l.delete();
      e_mv = 0; e_mm_s = '0; e_mm_l = '0; e_off_s = 0; e_off_l = 0;
    end else begin
      e_mv = pv;
      if (pv) begin
        probe_model(q_s, int'(pd[7:0]), e_mm_s, e_off_s);
        probe_model(q_l, int'(pd), e_mm_l, e_off_l);
      end
      if (fl) begin
        q_s.delete(); q_l.delete();
      end else if (iv) begin
        q_s.push_front(int'(d[7:0])); if (q_s.size() > DS) void'(q_s.pop_back());
        q_l.push_front(int'(d));      if (q_l.size() > DL) void'(q_l.pop_back());
      end
    end
    #1 check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(0, 16'h0, 0, 0, 16'h0);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 0; flush = 0; probe_valid = 0;
    in_data_s = '0; in_data_l = '0; probe_s = '0; probe_l = '0;
    e_mv = 0; e_mm_s = '0; e_mm_l = '0; e_off_s = 0; e_off_l = 0;

    // 1: reset state, then fill with 'A'..'G'
    do_reset();
    chk("reset_fill", 512'(fc_s), 512'(0));
    for (int i = 0; i < 7; i++) step(1, 16'("A" + i), 0, 0, 16'h0);
    chk("abc_win", 512'(win_s), 512'(56'h41424344454647));
    chk("abc_full", 512'(full_s), 512'(1));
    chk("abc_mask", 512'(vm_s), 512'(7'h7F));

    // 2: push while full drops the oldest entry
    step(1, 16'("H"), 0, 0, 16'h0);
    chk("h_win", 512'(win_s), 512'(56'h42434445464748));
    chk("h_fill", 512'(fc_s), 512'(7));

    // 3: nearest-match probe
    do_reset();
    step(1, 16'("A"), 0, 0, 16'h0);
    step(1, 16'("B"), 0, 0, 16'h0);
    step(1, 16'("C"), 0, 0, 16'h0);
    step(1, 16'("A"), 0, 0, 16'h0);
    step(0, 16'h0, 0, 1, 16'("A"));
    chk("pa_mask", 512'(mm_s), 512'(7'b0001001));
    chk("pa_off", 512'(off_s), 512'(1));
    step(0, 16'h0, 0, 1, 16'("Z"));
    chk("pz_hit", 512'(hit_s), 512'(0));
    step(0, 16'h0, 0, 0, 16'h0);
    chk("hold_mv", 512'(mv_s), 512'(0));

    // 4: invalid zero entries never match
    do_reset();
    step(0, 16'h0, 0, 1, 16'h0);
    chk("zero_hit", 512'(hit_s), 512'(0));
    step(1, 16'h0, 0, 0, 16'h0);
    step(0, 16'h0, 0, 1, 16'h0);
    chk("zero_off", 512'(off_s), 512'(1));

    // 5: flush with concurrent push and probe
    do_reset();
    step(1, 16'h61, 0, 0, 16'h0);
    step(1, 16'h62, 0, 0, 16'h0);
    step(1, 16'h63, 0, 0, 16'h0);
    step(1, 16'h78, 1, 1, 16'h61);
    chk("fl_fill", 512'(fc_s), 512'(0));
    chk("fl_off", 512'(off_s), 512'(3));

    // 6: same-cycle push/probe sees old window; mid-stream reset
    do_reset();
    step(1, 16'h51, 0, 1, 16'h51);
    chk("same_hit", 512'(hit_s), 512'(0));
    step(1, 16'h52, 0, 1, 16'h51);
    rst = 1'b0;
    step(1, 16'h53, 0, 1, 16'h52);
    chk("midrst_mv", 512'(mv_s), 512'(0));
    rst = 1'b1;

    // 7: random traffic on both geometries
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] d, p;
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      p = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      step(bit'($urandom_range(0, 3) != 0), d, bit'($urandom_range(0, 40) == 0),
           bit'($urandom_range(0, 1)), p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
